systolic_writeback: RTL

Result-drain engine for the 32x32 systolic multiplier. After a matrix multiply finishes, it steps the multiplier's `matrix_index` select through all 32 wrapped diagonals and captures each 32-lane `mul_outcome` vector. It requantizes every 21-bit accumulator to a signed 8-bit value and de-skews the diagonals into row order in an internal buffer. It then streams the 32x32 int8 result matrix to the output SRAM as packed 32-bit words.

---
 rtl/systolic_writeback.sv | 126 ++++++++++++
 1 files changed

// File: rtl/systolic_writeback.sv
// Result drain for the 32x32 systolic multiplier: captures wrapped
// diagonals, requantizes to int8, de-skews and streams rows to SRAM.
module systolic_writeback #(
  parameter int ARRAY_SIZE    = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int OUTCOME_WIDTH = 21,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [4:0]                          quant_shift,
  output logic [5:0]                          matrix_index,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
  output logic                                sram_wen,
  output logic [ADDR_WIDTH-1:0]               sram_waddr,
  output logic [31:0]                         sram_wdata,
  output logic                                busy,
  output logic                                done
);

  localparam int YW = OUTCOME_WIDTH + 1;
  localparam logic signed [YW-1:0] QMAX = YW'(127);
  localparam logic signed [YW-1:0] QMIN = YW'(-128);

  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;

  state_t state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [ADDR_WIDTH-1:0] base;
  logic [4:0] shift;
  logic [DATA_WIDTH-1:0] buff [ARRAY_SIZE][ARRAY_SIZE];

  logic [5:0] mi_next;
  logic wen_next, busy_next, done_next;
  logic [ADDR_WIDTH-1:0] waddr_next;
  logic [31:0] wdata_next;
  logic [4:0] row, col;

  // Round-half-up arithmetic shift, then clamp to int8.
  function automatic logic [DATA_WIDTH-1:0] quant(
    input logic [OUTCOME_WIDTH-1:0] x,
    input logic [4:0]               sh
  );
    logic signed [YW-1:0] rnd, y, z;
    rnd = '0;
    if (sh != 5'd0) rnd = YW'(1) << (sh - 5'd1);
    y = $signed({x[OUTCOME_WIDTH-1], x}) + rnd;
    z = y >>> sh;
    if (z > QMAX) quant = 8'h7f;
    else if (z < QMIN) quant = 8'h80;
    else quant = z[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      base         <= '0;
      shift        <= '0;
      matrix_index <= '0;
      sram_wen     <= 1'b0;
      sram_waddr   <= '0;
      sram_wdata   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      matrix_index <= mi_next;
      sram_wen     <= wen_next;
      sram_waddr   <= waddr_next;
      sram_wdata   <= wdata_next;
      busy         <= busy_next;
      done         <= done_next;
      if (state == IDLE && start) begin
        base  <= base_addr;
        shift <= quant_shift;
      end
    end
  end

  // Lane i carries column (k - i) mod 32 of row i.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        buff[i][5'(cnt[4:0] - 5'(i))] <=
          quant(mul_outcome[i*OUTCOME_WIDTH +: OUTCOME_WIDTH], shift);
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CAPTURE;
      CAPTURE: if (cnt == 8'd31) state_next = WRITE;
      WRITE:   if (cnt == 8'd255) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next = '0;
    if (state_next == state && state != IDLE) cnt_next = cnt + 8'd1;
    mi_next    = '0;
    wen_next   = 1'b0;
    waddr_next = '0;
    wdata_next = '0;
    row        = cnt_next[7:3];
    col        = {cnt_next[2:0], 2'b00};
    busy_next  = state_next != IDLE;
    done_next  = state_next == DONE;
    if (state_next == CAPTURE) mi_next = {1'b0, cnt_next[4:0]};
    if (state_next == WRITE) begin
      wen_next   = 1'b1;
      waddr_next = base + ADDR_WIDTH'(cnt_next);
      for (int b = 0; b < 4; b++) begin
        wdata_next[31-8*b -: 8] = buff[row][col + 5'(b)];
      end
    end
  end

endmodule
